// File: rtl/alu_issue_stage.sv
// alu_issue_stage: RV32I decode/issue stage that builds the ALU input bundle
// (ALU_Control, operand_A, operand_B, branch_op) and hands it to execute over
// a registered valid/ready interface. A two-entry skid buffer sustains one
// instruction per cycle under backpressure. in_ready is registered so there is
// no combinational path from out_ready back to in_ready.
//
// Optional build macro: ALU_ISSUE_ILLEGAL_TRAP_EN adds the `illegal` output.
// It is raised alongside the bundle for unsupported opcodes, R-type with a
// bad funct7 and branch funct3 010/011. Those cases issue as add 0,0 in both
// builds.
//
// state   | meaning
// --------+------------------------------------------------
// S_EMPTY | nothing held, out_valid=0
// S_ONE   | output register full, skid register empty
// S_TWO   | output and skid registers full, in_ready=0

module alu_issue_stage #(
  parameter int XLEN        = 32,
  parameter int LINK_OFFSET = 4
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] instruction,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5:0]      ALU_Control,
  output logic [XLEN-1:0] operand_A,
  output logic [XLEN-1:0] operand_B,
  output logic            branch_op
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  ,
  output logic            illegal
`endif
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [5:0]      ctrl;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            br;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    logic            ill;
`endif
  } bundle_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t  state_q, state_d;
  bundle_t out_q, out_d;
  bundle_t skid_q, skid_d;
  logic    in_ready_q, in_ready_d;
  bundle_t dec;
  logic    accept;
  logic    fire;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] shamt;
  logic [XLEN-1:0] link_addr;
  logic [XLEN-1:0] jalr_target;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign funct7 = instruction[31:25];

  assign imm_i = {{(XLEN-12){instruction[31]}}, instruction[31:20]};
  assign imm_s = {{(XLEN-12){instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_j = {{(XLEN-20){instruction[31]}}, instruction[19:12], instruction[20],
                  instruction[30:21], 1'b0};
  assign imm_u = {instruction[31:12], 12'b0};
  assign shamt = {{(XLEN-5){1'b0}}, instruction[24:20]};

  // Link value and jalr target wrap modulo 2^XLEN; jalr target has bit 0 cleared.
  assign link_addr   = pc + XLEN'(LINK_OFFSET);
  assign jalr_target = (rs1_data + imm_i) & ~XLEN'(1);

  assign accept   = in_valid && in_ready_q;
  assign fire     = out_valid && out_ready;
  assign in_ready = in_ready_q;

  // Decode the incoming instruction into an ALU bundle; anything not decoded stays add 0,0.
  always_comb begin
    dec = '0;
    case (opcode)
      OP_R: begin
        if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
          dec.ctrl = {2'b00, instruction[30], funct3};
          dec.a    = rs1_data;
          dec.b    = rs2_data;
        end
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        else begin
          dec.ill = 1'b1;
        end
`endif
      end
      OP_I: begin
        dec.ctrl = {2'b00, (funct3 == 3'b101) ? instruction[30] : 1'b0, funct3};
        dec.a    = rs1_data;
        dec.b    = (funct3 == 3'b001 || funct3 == 3'b101) ? shamt : imm_i;
      end
      OP_BRANCH: begin
        if (funct3 != 3'b010 && funct3 != 3'b011) begin
          dec.ctrl = {3'b010, funct3};
          dec.a    = rs1_data;
          dec.b    = rs2_data;
          dec.br   = 1'b1;
        end
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        else begin
          dec.ill = 1'b1;
        end
`endif
      end
      OP_JAL: begin
        dec.ctrl = 6'b011111;
        dec.a    = link_addr;
        dec.b    = imm_j;
        dec.br   = 1'b1;
      end
      OP_JALR: begin
        dec.ctrl = 6'b111111;
        dec.a    = link_addr;
        dec.b    = jalr_target;
        dec.br   = 1'b1;
      end
      OP_LOAD: begin
        dec.a = rs1_data;
        dec.b = imm_i;
      end
      OP_STORE: begin
        dec.a = rs1_data;
        dec.b = imm_s;
      end
      OP_LUI: begin
        dec.b = imm_u;
      end
      OP_AUIPC: begin
        dec.a = pc;
        dec.b = imm_u;
      end
      OP_FENCE, OP_SYSTEM: begin
        dec = '0;
      end
      default: begin
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        dec.ill = 1'b1;
`endif
      end
    endcase
  end

  // Skid FSM state register; reset discards both entries immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Skid FSM next state from accept/fire.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (accept) state_d = S_ONE;
      S_ONE: begin
        if (accept && !fire)      state_d = S_TWO;
        else if (!accept && fire) state_d = S_EMPTY;
      end
      S_TWO: if (fire) state_d = S_ONE;
      default: state_d = S_EMPTY;
    endcase
  end

  // Skid FSM outputs: valid flag, register loads and the registered ready.
  always_comb begin
    out_valid  = (state_q != S_EMPTY);
    out_d      = out_q;
    skid_d     = skid_q;
    in_ready_d = (state_d != S_TWO);
    case (state_q)
      S_EMPTY: if (accept) out_d = dec;
      S_ONE: begin
        if (accept && fire) out_d  = dec;
        else if (accept)    skid_d = dec;
      end
      S_TWO: if (fire) out_d = skid_q;
      default: ;
    endcase
  end

  // Output, skid and ready registers. in_ready comes up one cycle after reset release.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_q      <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign ALU_Control = out_q.ctrl;
  assign operand_A   = out_q.a;
  assign operand_B   = out_q.b;
  assign branch_op   = out_q.br;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  assign illegal     = out_q.ill;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed steps followed by a
// randomized phase checked against a queue-based reference model.
module tb_alu_issue_stage;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instruction = '0;
  logic [31:0] pc = '0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [5:0]  ALU_Control;
  logic [31:0] operand_A;
  logic [31:0] operand_B;
  logic        branch_op;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [5:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic        br;
    logic        ill;
  } exp_t;

  alu_issue_stage #(.XLEN(32), .LINK_OFFSET(4)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instruction (instruction),
    .pc          (pc),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .ALU_Control (ALU_Control),
    .operand_A   (operand_A),
    .operand_B   (operand_B),
    .branch_op   (branch_op)
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    ,
    .illegal     (illegal)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_bundle(input string tag, input exp_t e);
    chk({tag, ".ctrl"}, 32'(ALU_Control), 32'(e.ctrl));
    chk({tag, ".A"}, operand_A, e.a);
    chk({tag, ".B"}, operand_B, e.b);
    chk({tag, ".br"}, 32'(branch_op), 32'(e.br));
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    chk({tag, ".ill"}, 32'(illegal), 32'(e.ill));
`endif
  endtask

  // Behavioural reference: rule-by-rule from the instruction fields, integer arithmetic.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pcv,
                                 input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    int op, f3, f7, ii, si, ji;
    e = '{ctrl: 6'd0, a: 32'd0, b: 32'd0, br: 1'b0, ill: 1'b0};
    op = int'(ins[6:0]);
    f3 = int'(ins[14:12]);
    f7 = int'(ins[31:25]);
    ii = int'(ins[31:20]);
    if (ii >= 2048) ii -= 4096;
    si = int'(ins[31:25]) * 32 + int'(ins[11:7]);
    if (si >= 2048) si -= 4096;
    ji = int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
    if (ins[31]) ji -= 1048576;
    case (op)
      'h33: if (f7 == 0 || f7 == 32) begin
              e.ctrl = 6'((f7 == 32 ? 8 : 0) + f3); e.a = r1; e.b = r2;
            end else e.ill = 1'b1;
      'h13: begin
              e.ctrl = 6'(((f3 == 5 && ins[30]) ? 8 : 0) + f3);
              e.a = r1;
              e.b = (f3 == 1 || f3 == 5) ? 32'(ins[24:20]) : ii;
            end
      'h63: if (f3 == 2 || f3 == 3) e.ill = 1'b1;
            else begin e.ctrl = 6'(16 + f3); e.a = r1; e.b = r2; e.br = 1'b1; end
      'h6F: begin e.ctrl = 6'd31; e.a = pcv + 32'd4; e.b = ji; e.br = 1'b1; end
      'h67: begin e.ctrl = 6'd63; e.a = pcv + 32'd4; e.b = (r1 + ii) & 32'hFFFF_FFFE; e.br = 1'b1; end
      'h03: begin e.a = r1; e.b = ii; end
      'h23: begin e.a = r1; e.b = si; end
      'h37: e.b = ins & 32'hFFFF_F000;
      'h17: begin e.a = pcv; e.b = ins & 32'hFFFF_F000; end
      'h0F, 'h73: ;
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  ops [11];
    int k;
    ops = '{7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h37, 7'h17, 7'h0F, 7'h73};
    w = $urandom;
    k = $urandom_range(0, 11);
    if (k < 11) w[6:0] = ops[k];
    if (w[6:0] == 7'h33 && $urandom_range(0, 3) != 0)
      w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    return w;
  endfunction

  task automatic drive(input logic [31:0] ins, input logic [31:0] pcv,
                       input logic [31:0] r1, input logic [31:0] r2);
    in_valid = 1'b1; instruction = ins; pc = pcv; rs1_data = r1; rs2_data = r2;
  endtask

  // Send one instruction (queue assumed drained) and check the bundle one cycle later.
  task automatic send_dir(input string tag, input logic [31:0] ins, input logic [31:0] pcv,
                          input logic [31:0] r1, input logic [31:0] r2,
                          input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic br, input logic ill);
    exp_t e;
    e = '{ctrl: c, a: a, b: b, br: br, ill: ill};
    drive(ins, pcv, r1, r2);
    @(negedge clock);
    in_valid = 1'b0;
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk_bundle(tag, e);
  endtask

  exp_t q[$];
  exp_t e_add, e_sub, e_xor;
  logic fire, acc;

  initial begin
    e_add = '{ctrl: 6'd0, a: 32'd1,  b: 32'd2, br: 1'b0, ill: 1'b0};
    e_sub = '{ctrl: 6'd8, a: 32'd10, b: 32'd3, br: 1'b0, ill: 1'b0};
    e_xor = '{ctrl: 6'd4, a: 32'd6,  b: 32'd7, br: 1'b0, ill: 1'b0};

    // Reset held
    repeat (2) @(negedge clock);
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.ctrl", 32'(ALU_Control), 32'd0);
    chk("rst.A", operand_A, 32'd0);
    chk("rst.B", operand_B, 32'd0);
    chk("rst.br", 32'(branch_op), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rel.in_ready", 32'(in_ready), 32'd1);
    chk("rel.valid", 32'(out_valid), 32'd0);

    // Directed decode cases
    send_dir("add",   32'h002081B3, 32'h0,        32'd4,        32'd5,        6'b000000, 32'd4,        32'd5,        1'b0, 1'b0);
    send_dir("sub",   32'h402081B3, 32'h0,        32'd4,        32'd5,        6'b001000, 32'd4,        32'd5,        1'b0, 1'b0);
    send_dir("srai",  32'h4020D093, 32'h0,        32'h80,       32'd0,        6'b001101, 32'h80,       32'd2,        1'b0, 1'b0);
    send_dir("slti",  32'hFFF0A093, 32'h0,        32'd7,        32'd0,        6'b000010, 32'd7,        32'hFFFFFFFF, 1'b0, 1'b0);
    send_dir("blt",   32'h0020C063, 32'h0,        32'hFFFFFFF0, 32'hFFFFFFFF, 6'b010100, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1, 1'b0);
    send_dir("jal",   32'h008000EF, 32'h100,      32'd0,        32'd0,        6'b011111, 32'h104,      32'd8,        1'b1, 1'b0);
    send_dir("jalr",  32'h000080E7, 32'h100,      32'h203,      32'd0,        6'b111111, 32'h104,      32'h202,      1'b1, 1'b0);
    send_dir("jalwr", 32'h008000EF, 32'hFFFFFFFC, 32'd0,        32'd0,        6'b011111, 32'h0,        32'd8,        1'b1, 1'b0);
    send_dir("fence", 32'h0000000F, 32'h40,       32'h55,       32'h66,       6'b000000, 32'h0,        32'h0,        1'b0, 1'b0);
    send_dir("lui",   32'h12345037, 32'h40,       32'h99,       32'h0,        6'b000000, 32'h0,        32'h12345000, 1'b0, 1'b0);
    send_dir("badbr", 32'h0020A063, 32'h40,       32'd1,        32'd2,        6'b000000, 32'h0,        32'h0,        1'b0, 1'b1);
    send_dir("badop", 32'h0000007B, 32'h40,       32'd1,        32'd2,        6'b000000, 32'h0,        32'h0,        1'b0, 1'b1);
    @(negedge clock);
    chk("drain.valid", 32'(out_valid), 32'd0);

    // Backpressure: 3 streamed, 2 accepted, hold stable, drain in order
    out_ready = 1'b0;
    drive(32'h002081B3, 32'h0, 32'd1, 32'd2);
    @(negedge clock);
    drive(32'h402081B3, 32'h0, 32'd10, 32'd3);
    @(negedge clock);
    chk("bp.in_ready", 32'(in_ready), 32'd0);
    drive(32'h0020C1B3, 32'h0, 32'd6, 32'd7);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("bp.hold_valid", 32'(out_valid), 32'd1);
      chk("bp.hold_ready", 32'(in_ready), 32'd0);
      chk_bundle("bp.hold", e_add);
    end
    out_ready = 1'b1;
    @(negedge clock);
    chk("bp.second_valid", 32'(out_valid), 32'd1);
    chk("bp.second_ready", 32'(in_ready), 32'd1);
    chk_bundle("bp.second", e_sub);
    @(negedge clock);
    in_valid = 1'b0;
    chk("bp.third_valid", 32'(out_valid), 32'd1);
    chk_bundle("bp.third", e_xor);
    @(negedge clock);
    chk("bp.empty", 32'(out_valid), 32'd0);

    // Reset while both entries are full
    out_ready = 1'b0;
    drive(32'h002081B3, 32'h0, 32'd1, 32'd2);
    @(negedge clock);
    drive(32'h402081B3, 32'h0, 32'd10, 32'd3);
    @(negedge clock);
    in_valid = 1'b0;
    chk("mr.full_valid", 32'(out_valid), 32'd1);
    chk("mr.full_ready", 32'(in_ready), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("mr.async_valid", 32'(out_valid), 32'd0);
    chk("mr.async_ctrl", 32'(ALU_Control), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clock);
    chk("mr.rel_ready", 32'(in_ready), 32'd1);
    chk("mr.rel_valid", 32'(out_valid), 32'd0);
    send_dir("mr.first", 32'h002081B3, 32'h0, 32'd4, 32'd5, 6'b000000, 32'd4, 32'd5, 1'b0, 1'b0);
    @(negedge clock);
    chk("mr.nodup", 32'(out_valid), 32'd0);

    // Randomized traffic against the 2-deep queue model
    for (int c = 0; c < 600; c++) begin
      chk("rnd.valid", 32'(out_valid), 32'(q.size() > 0));
      chk("rnd.ready", 32'(in_ready), 32'(q.size() < 2));
      if (q.size() > 0) chk_bundle("rnd", q[0]);
      out_ready   = ($urandom_range(0, 3) != 0);
      in_valid    = ($urandom_range(0, 3) != 0);
      instruction = rand_instr();
      pc          = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom;
      rs1_data    = $urandom;
      rs2_data    = $urandom;
      fire = out_ready && (q.size() > 0);
      acc  = in_valid && (q.size() < 2);
      @(posedge clock);
      if (fire) void'(q.pop_front());
      if (acc) q.push_back(model(instruction, pc, rs1_data, rs2_data));
      @(negedge clock);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
